timer_seq: RTL

Sequencer and controller for a 16-bit loadable down counter used as a programmable interval timer.
- Holds the reload value, loads the counter, and gates decrement enables from a prescaled external TICK.
- Detects terminal count and reloads (periodic mode) or stops (one-shot mode).
- Raises a sticky interrupt.
- Sits on the chip's internal byte-wide register bus alongside the other peripheral register blocks.

---
 rtl/timer_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/timer_seq.sv
// timer_seq: sequencer/controller for a 16-bit programmable interval timer.
// Byte-wide register bus (reload low/high, control), prescaled TICK gating,
// periodic or one-shot terminal count, sticky interrupt.
module timer_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PS_W  = 8
) (
    input  logic             CLK,
    input  logic             RSTL,
    input  logic             WR,
    input  logic [1:0]       ADDR,
    input  logic [7:0]       DIN,
    input  logic             TICK,
    input  logic             IACK,
    output logic [WIDTH-1:0] CNT,
    output logic             RUN,
    output logic             TC,
    output logic             INT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] cnt_nxt;
    logic [PS_W-1:0]  ps;
    logic [PS_W-1:0]  ps_nxt;
    logic [PS_W-1:0]  ps_max;
    logic             oneshot_q;
    logic             ien_q;
    logic [2:0]       psel_q;
    logic             tc_nxt;
    logic             int_nxt;
    logic             ctrl_wr;
    logic             unused_din;

    // Control bits [7:6] carry no function.
    assign unused_din = ^DIN[7:6];

    assign ctrl_wr = WR && (ADDR == 2'd2);
    assign ps_max  = (PS_W'(1) << psel_q) - PS_W'(1);
    assign RUN     = (state == S_RUN);

    // State register.
    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a control write overrides everything else in its cycle.
    always_comb begin
        state_nxt = state;
        if (ctrl_wr) begin
            state_nxt = DIN[0] ? S_LOAD : S_IDLE;
        end else begin
            case (state)
                S_LOAD: state_nxt = S_RUN;
                S_RUN: begin
                    if (TICK && (ps == ps_max) && (CNT == '0) && oneshot_q) begin
                        state_nxt = S_DONE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Counter, prescaler, terminal count and interrupt next values.
    always_comb begin
        cnt_nxt = CNT;
        ps_nxt  = ps;
        tc_nxt  = 1'b0;
        int_nxt = INT && !IACK;
        if (!ctrl_wr) begin
            if (state == S_LOAD) begin
                cnt_nxt = reload;
                ps_nxt  = '0;
            end else if ((state == S_RUN) && TICK) begin
                if (ps == ps_max) begin
                    ps_nxt = '0;
                    if (CNT != '0) begin
                        cnt_nxt = CNT - WIDTH'(1);
                    end else begin
                        tc_nxt = 1'b1;
                        // A new terminal count beats a simultaneous IACK.
                        if (ien_q) begin
                            int_nxt = 1'b1;
                        end
                        if (!oneshot_q) begin
                            cnt_nxt = reload;
                        end
                    end
                end else begin
                    ps_nxt = ps + PS_W'(1);
                end
            end
        end
    end

    // Datapath and register-bus state.
    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            CNT       <= '0;
            ps        <= '0;
            reload    <= '0;
            oneshot_q <= 1'b0;
            ien_q     <= 1'b0;
            psel_q    <= '0;
            TC        <= 1'b0;
            INT       <= 1'b0;
        end else begin
            CNT <= cnt_nxt;
            ps  <= ps_nxt;
            TC  <= tc_nxt;
            INT <= int_nxt;
            if (WR && (ADDR == 2'd0)) begin
                reload[7:0] <= DIN;
            end
            if (WR && (ADDR == 2'd1)) begin
                reload[WIDTH-1 -: 8] <= DIN;
            end
            if (ctrl_wr) begin
                oneshot_q <= DIN[1];
                ien_q     <= DIN[2];
                psel_q    <= DIN[5:3];
            end
        end
    end

endmodule
